// File: rtl/wbm_pkg.sv
// Shared types and Wishbone cycle-type codes for the burst master and its write FIFO.
package wbm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BUS,
        DONE
    } wbm_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wbm_wfifo.sv
// Write-data FIFO holding one burst of {sel, data} beats; head entry is always visible.
module wbm_wfifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic             sys_clk,
    input  logic             RESETN,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count == CNT_MAX);
    assign empty     = (count == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (!RESETN || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge sys_clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B4 incrementing-burst master: turns app commands into cti-tagged bursts,
// buffering a whole write burst before the cycle and streaming read data back registered.
module wb_burst_master
    import wbm_pkg::*;
#(
    parameter int dw     = 32,
    parameter int APP_AW = 26,
    parameter int MAX_BL = 8,
    parameter int BL_W   = $clog2(MAX_BL) + 1
) (
    input  logic              sys_clk,
    input  logic              RESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [APP_AW-1:0] cmd_addr,
    input  logic [BL_W-1:0]   cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [dw-1:0]     wr_data,
    input  logic [dw/8-1:0]   wr_sel,
    output logic              rd_valid,
    output logic [dw-1:0]     rd_data,
    output logic              done,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [dw-1:0]     wb_dat_o,
    output logic [dw/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [dw-1:0]     wb_dat_i
);

    localparam int SW = dw / 8;
    localparam logic [APP_AW-1:0] BEAT_BYTES = APP_AW'(SW);
    localparam logic [BL_W-1:0]   LEN_ONE    = BL_W'(1);
    localparam logic [BL_W-1:0]   LEN_TWO    = BL_W'(2);
    localparam logic [BL_W-1:0]   LEN_MAX    = BL_W'(MAX_BL);

    function automatic logic [BL_W-1:0] clamp_len(input logic [BL_W-1:0] l);
        if (l == '0)     return LEN_ONE;
        if (l > LEN_MAX) return LEN_MAX;
        return l;
    endfunction

    function automatic logic [2:0] first_cti(input logic [BL_W-1:0] l);
        return (l == LEN_ONE) ? CTI_EOB : CTI_INCR;
    endfunction

    wbm_state_e        state;
    logic [BL_W-1:0]   len_q;
    logic [BL_W-1:0]   beat_q;
    logic [BL_W-1:0]   load_cnt_q;
    logic [APP_AW-1:0] addr_q;
    logic [BL_W-1:0]   cmd_len_c;
    logic [dw+SW-1:0]  head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              cmd_fire;
    logic              push;
    logic              pop;
    logic              bus_ack;
    logic              last_beat;
    logic              last_push;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign cmd_len_c = clamp_len(cmd_len);
    assign push      = wr_valid && wr_ready && !fifo_full;
    assign bus_ack   = wb_stb_o && wb_ack_i;
    assign pop       = bus_ack && wb_we_o && !fifo_empty;
    assign last_beat = (beat_q == len_q - LEN_ONE);
    assign last_push = (load_cnt_q == len_q - LEN_ONE);

    // Data and byte lanes are the FIFO head during a write beat, all lanes on reads, idle-low otherwise.
    assign wb_dat_o = (wb_stb_o && wb_we_o) ? head[dw-1:0] : '0;
    assign wb_sel_o = !wb_stb_o ? '0 : (wb_we_o ? head[dw+SW-1:dw] : {SW{1'b1}});

    wbm_wfifo #(
        .WIDTH (dw + SW),
        .DEPTH (MAX_BL)
    ) u_wfifo (
        .sys_clk   (sys_clk),
        .RESETN    (RESETN),
        .flush     (cmd_fire),
        .push      (push),
        .push_data ({wr_sel, wr_data}),
        .pop       (pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge sys_clk) begin
        if (!RESETN) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            wr_ready   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            done       <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_addr_o  <= '0;
            wb_cti_o   <= CTI_CLASSIC;
            len_q      <= '0;
            beat_q     <= '0;
            load_cnt_q <= '0;
            addr_q     <= '0;
        end else begin
            rd_valid <= bus_ack && !wb_we_o;
            if (bus_ack && !wb_we_o) rd_data <= wb_dat_i;
            done <= 1'b0;

            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_fire) begin
                        cmd_ready  <= 1'b0;
                        len_q      <= cmd_len_c;
                        addr_q     <= cmd_addr;
                        beat_q     <= '0;
                        load_cnt_q <= '0;
                        if (cmd_we) begin
                            state    <= LOAD;
                            wr_ready <= 1'b1;
                        end else begin
                            state     <= BUS;
                            wb_cyc_o  <= 1'b1;
                            wb_stb_o  <= 1'b1;
                            wb_we_o   <= 1'b0;
                            wb_addr_o <= cmd_addr;
                            wb_cti_o  <= first_cti(cmd_len_c);
                        end
                    end
                end

                LOAD: begin
                    if (push) begin
                        load_cnt_q <= load_cnt_q + LEN_ONE;
                        if (last_push) begin
                            wr_ready  <= 1'b0;
                            state     <= BUS;
                            wb_cyc_o  <= 1'b1;
                            wb_stb_o  <= 1'b1;
                            wb_we_o   <= 1'b1;
                            wb_addr_o <= addr_q;
                            wb_cti_o  <= first_cti(len_q);
                        end
                    end
                end

                BUS: begin
                    if (bus_ack) begin
                        if (last_beat) begin
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            wb_we_o  <= 1'b0;
                            wb_cti_o <= CTI_CLASSIC;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            beat_q    <= beat_q + LEN_ONE;
                            wb_addr_o <= wb_addr_o + BEAT_BYTES;
                            wb_cti_o  <= (beat_q + LEN_TWO == len_q) ? CTI_EOB : CTI_INCR;
                        end
                    end
                end

                DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: beat-list model with a per-cycle compare process and literal pins.
module tb_wb_burst_master;

    logic        sys_clk;
    logic        RESETN;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [25:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_sel;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [25:0] wb_addr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic        wb_ack_i = 1'b0;
    logic [31:0] wb_dat_i = 32'h0;

    wb_burst_master dut (
        .sys_clk   (sys_clk),
        .RESETN    (RESETN),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_sel    (wr_sel),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_addr_o (wb_addr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_cti_o  (wb_cti_o),
        .wb_ack_i  (wb_ack_i),
        .wb_dat_i  (wb_dat_i)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        logic [25:0] addr;
        logic        we;
        logic [2:0]  cti;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [25:0] obs_addr[$];
    logic [2:0]  obs_cti[$];
    logic [31:0] wdata[16];
    logic [3:0]  wsel[16];

    int n_chk = 0;
    int n_err = 0;
    int rd_cnt = 0;
    int waits = 0;
    int wcnt = 0;
    bit chk_en = 0;
    bit force_ack = 0;

    logic        p_stb = 0, p_end = 0, p_end2 = 0, p_rd = 0;
    logic [31:0] p_rd_data = '0;

    function automatic logic [31:0] slave_data(input logic [25:0] a);
        return 32'hC0DE0000 ^ {6'h0, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Slave response followed by the comparison of every output against the beat model.
    always @(negedge sys_clk) begin
        beat_t       e;
        logic        n_rd, n_end;
        logic [31:0] n_rd_data;
        if (force_ack) wb_ack_i = 1'b1;
        else if (wb_stb_o) begin
            if (wcnt < waits) begin wb_ack_i = 1'b0; wcnt++; end
            else begin wb_ack_i = 1'b1; wcnt = 0; end
        end else begin
            wb_ack_i = 1'b0;
            wcnt = 0;
        end
        wb_dat_i = wb_ack_i ? slave_data(wb_addr_o) : 32'h0;

        n_rd = 0; n_end = 0; n_rd_data = '0;
        if (!chk_en) begin
            p_stb = 0; p_end = 0; p_end2 = 0; p_rd = 0; p_rd_data = '0;
        end else begin
            check("cyc_vs_stb", 64'(wb_cyc_o), 64'(wb_stb_o));
            if (p_stb) check("stb_level", 64'(wb_stb_o), 64'(!p_end));
            if (!wb_cyc_o) check("cti_idle", 64'(wb_cti_o), 64'd0);
            if (wb_stb_o) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_beat: addr %0h with no pending beat", wb_addr_o);
                end else begin
                    e = exp_q[0];
                    check("addr", 64'(wb_addr_o), 64'(e.addr));
                    check("we", 64'(wb_we_o), 64'(e.we));
                    check("cti", 64'(wb_cti_o), 64'(e.cti));
                    check("sel", 64'(wb_sel_o), 64'(e.sel));
                    if (e.we) check("dat", 64'(wb_dat_o), 64'(e.dat));
                    if (wb_ack_i) begin
                        obs_addr.push_back(wb_addr_o);
                        obs_cti.push_back(wb_cti_o);
                        void'(exp_q.pop_front());
                        n_rd = !e.we;
                        n_rd_data = slave_data(e.addr);
                        n_end = e.last;
                    end
                end
            end
            check("rd_valid", 64'(rd_valid), 64'(p_rd));
            if (p_rd) check("rd_data", 64'(rd_data), 64'(p_rd_data));
            if (rd_valid) rd_cnt++;
            check("done", 64'(done), 64'(p_end));
            if (p_end)  check("cmd_ready_in_done", 64'(cmd_ready), 64'd0);
            if (p_end2) check("cmd_ready_after_done", 64'(cmd_ready), 64'd1);
            p_end2 = p_end;
            p_stb = wb_stb_o;
            p_end = n_end;
            p_rd = n_rd;
            p_rd_data = n_rd_data;
        end
    end

    task automatic issue(input logic we, input logic [25:0] addr, input logic [3:0] len);
        int eff;
        bit hs;
        beat_t b;
        eff = (len == 0) ? 1 : ((len > 8) ? 8 : int'(len));
        cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        hs = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge sys_clk);
            if (cmd_ready) begin hs = 1; break; end
        end
        if (!hs) begin
            timeout("cmd_handshake");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < eff; i++) begin
            b.addr = addr + 26'(i * 4);
            b.we   = we;
            b.cti  = (i == eff - 1) ? 3'b111 : 3'b010;
            b.dat  = we ? wdata[i] : 32'h0;
            b.sel  = we ? wsel[i] : 4'hF;
            b.last = (i == eff - 1);
            exp_q.push_back(b);
        end
        if (we) begin
            for (int i = 0; i < eff; i++) begin
                wr_valid = 1'b1; wr_data = wdata[i]; wr_sel = wsel[i];
                hs = 0;
                for (int k = 0; k < 50; k++) begin
                    @(negedge sys_clk);
                    if (wr_ready) begin hs = 1; break; end
                end
                if (!hs) begin timeout("wr_handshake"); break; end
                @(posedge sys_clk); #1;
            end
            wr_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        bit hit;
        hit = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge sys_clk);
            if (done) begin hit = 1; break; end
        end
        if (!hit) timeout(name);
        @(posedge sys_clk); #1;
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_cti.delete();
        rd_cnt = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        bit hit;
        RESETN = 1'b0; cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 0; wr_data = '0; wr_sel = '0;
        for (int i = 0; i < 16; i++) begin wdata[i] = 32'hA0 + i; wsel[i] = 4'hF; end

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cyc", 64'(wb_cyc_o), 64'd0);
        check("rst_stb", 64'(wb_stb_o), 64'd0);
        check("rst_we", 64'(wb_we_o), 64'd0);
        check("rst_addr", 64'(wb_addr_o), 64'd0);
        check("rst_dat", 64'(wb_dat_o), 64'd0);
        check("rst_sel", 64'(wb_sel_o), 64'd0);
        check("rst_cti", 64'(wb_cti_o), 64'd0);
        @(posedge sys_clk); #1;
        RESETN = 1'b1;
        chk_en = 1;

        // Write burst, zero-wait slave
        waits = 0; clear_obs();
        issue(1'b1, 26'h100, 4'd4);
        wait_done("t1_done");
        check("t1_beats", 64'(obs_addr.size()), 64'd4);
        check("t1_addr0", 64'(obs_addr[0]), 64'h100);
        check("t1_addr1", 64'(obs_addr[1]), 64'h104);
        check("t1_addr2", 64'(obs_addr[2]), 64'h108);
        check("t1_addr3", 64'(obs_addr[3]), 64'h10C);
        check("t1_cti2", 64'(obs_cti[2]), 64'h2);
        check("t1_cti3", 64'(obs_cti[3]), 64'h7);

        // Read burst, two wait states per beat
        waits = 2; clear_obs();
        issue(1'b0, 26'h200, 4'd8);
        wait_done("t2_done");
        check("t2_rd_pulses", 64'(rd_cnt), 64'd8);
        check("t2_addr7", 64'(obs_addr[7]), 64'h21C);
        check("t2_cti6", 64'(obs_cti[6]), 64'h2);
        check("t2_cti7", 64'(obs_cti[7]), 64'h7);

        // Single beat and address wrap at the top of the space
        waits = 1; clear_obs();
        issue(1'b0, 26'h3FFFFFC, 4'd1);
        wait_done("t3a_done");
        check("t3a_beats", 64'(obs_addr.size()), 64'd1);
        check("t3a_addr", 64'(obs_addr[0]), 64'h3FFFFFC);
        check("t3a_cti", 64'(obs_cti[0]), 64'h7);
        clear_obs();
        issue(1'b0, 26'h3FFFFFC, 4'd2);
        wait_done("t3b_done");
        check("t3b_cti0", 64'(obs_cti[0]), 64'h2);
        check("t3b_wrap_addr", 64'(obs_addr[1]), 64'h0);

        // Stray inputs while idle: ack without stb, wr_valid outside LOAD
        waits = 0;
        force_ack = 1;
        wr_valid = 1'b1; wr_data = 32'hDEADBEEF; wr_sel = 4'h5;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            check("idle_wr_ready", 64'(wr_ready), 64'd0);
        end
        @(posedge sys_clk); #1;
        force_ack = 0;
        wr_valid = 1'b0;

        // Length clamping
        clear_obs();
        for (int i = 0; i < 16; i++) begin wdata[i] = 32'h5500_0000 + 32'(i * 17); wsel[i] = 4'(i + 3); end
        issue(1'b1, 26'h40, 4'd0);
        wait_done("t4a_done");
        check("t4a_beats", 64'(obs_addr.size()), 64'd1);
        clear_obs();
        issue(1'b1, 26'h80, 4'd15);
        wait_done("t4b_done");
        check("t4b_beats", 64'(obs_addr.size()), 64'd8);
        check("t4b_addr7", 64'(obs_addr[7]), 64'h9C);
        check("t4b_cti7", 64'(obs_cti[7]), 64'h7);

        // Reset during beat 2 of a 4-beat write
        waits = 2; clear_obs();
        for (int i = 0; i < 16; i++) begin wdata[i] = 32'h0BAD_0000 + 32'(i); wsel[i] = 4'hF; end
        issue(1'b1, 26'h500, 4'd4);
        hit = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge sys_clk);
            if (exp_q.size() == 3 && wb_stb_o) begin hit = 1; break; end
        end
        if (!hit) timeout("t5_beat2");
        RESETN = 1'b0;
        chk_en = 0;
        @(negedge sys_clk);
        check("t5_cyc", 64'(wb_cyc_o), 64'd0);
        check("t5_stb", 64'(wb_stb_o), 64'd0);
        check("t5_cti", 64'(wb_cti_o), 64'd0);
        check("t5_cmd_ready", 64'(cmd_ready), 64'd0);
        @(posedge sys_clk); #1;
        RESETN = 1'b1;
        exp_q.delete();
        clear_obs();
        waits = 0;
        chk_en = 1;
        for (int i = 0; i < 16; i++) begin wdata[i] = 32'hB0 + i; wsel[i] = 4'hF; end
        issue(1'b1, 26'h600, 4'd4);
        wait_done("t5_fresh_done");
        check("t5_fresh_beats", 64'(obs_addr.size()), 64'd4);
        check("t5_fresh_addr0", 64'(obs_addr[0]), 64'h600);

        // Back-to-back writes
        clear_obs();
        for (int i = 0; i < 16; i++) begin wdata[i] = 32'hC000_0000 | 32'(i << 4); wsel[i] = 4'hA; end
        issue(1'b1, 26'h700, 4'd2);
        wait_done("t6a_done");
        for (int i = 0; i < 16; i++) begin wdata[i] = 32'hD000_0000 | 32'(i); wsel[i] = 4'h3; end
        issue(1'b1, 26'h720, 4'd3);
        wait_done("t6b_done");
        check("t6_beats", 64'(obs_addr.size()), 64'd5);
        check("t6_addr2", 64'(obs_addr[2]), 64'h720);
        check("t6_pending", 64'(exp_q.size()), 64'd0);

        repeat (3) @(posedge sys_clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
